// File: rtl/spmc_spi_slave_pkg.sv
// Shared constants for the SpartanMC SPI responder: register offsets, CTRL/STATUS bit
// positions and the byte engine state encoding.
package spmc_spi_slave_pkg;

  localparam logic [5:0] REG_DATA   = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_CTRL   = 6'd2;

  localparam int unsigned CTRL_CPHA     = 0;
  localparam int unsigned CTRL_CPOL     = 1;
  localparam int unsigned CTRL_EN       = 2;
  localparam int unsigned CTRL_IE_RX    = 3;
  localparam int unsigned CTRL_IE_FRAME = 4;

  localparam int unsigned ST_RX_NEMPTY  = 0;
  localparam int unsigned ST_RX_FULL    = 1;
  localparam int unsigned ST_TX_EMPTY   = 2;
  localparam int unsigned ST_TX_FULL    = 3;
  localparam int unsigned ST_OVR        = 4;
  localparam int unsigned ST_UDR        = 5;
  localparam int unsigned ST_CS_ACTIVE  = 6;
  localparam int unsigned ST_FRAME      = 7;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } engine_state_e;

endpackage

// File: rtl/pselect.sv
// Peripheral select: compares the upper address bits against a fixed base and qualifies
// the match with the bus access strobe.
module pselect #(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  activ_peri,
  output logic                  select
);

  assign select = activ_peri & (addr == BASE_ADDR);

endmodule

// File: rtl/spi_slave_fifo.sv
// Synchronous FIFO with wrapping pointers and a one-bit-wider occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_slave_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_peri,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en)      count_q <= count_q + (AW + 1)'(1);
      else if (rd_en && !wr_en) count_q <= count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_peri) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spmc_spi_slave.sv
// SpartanMC SPI responder: oversamples the external SPI pins in the clk_peri domain,
// shifts bytes between the pins and byte-wide RX/TX FIFOs on the peripheral bus.
module spmc_spi_slave
  import spmc_spi_slave_pkg::*;
#(
  parameter logic [9:0]  BASE_ADR      = 10'h0,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic sclk_s1, sclk_s2, sclk_q, mosi_s1, mosi_s2, cs_s1, cs_s2, cs_q;
  logic sel, bus_wr, bus_rd, status_wr, ctrl_wr;
  logic [5:0] off;
  logic [4:0] ctrl_q;
  logic ovr_q, udr_q, frame_q, irq_q;
  logic ovr_set, udr_set, frame_set;
  logic [7:0] status, rd_val;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head, rx_byte, load_byte;
  logic [CntW-1:0] tx_count, rx_count;

  engine_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic miso_q, miso_d, skip_q, skip_d, done_q, done_d, got_byte_q, got_byte_d;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  logic unused_bits;
  assign unused_bits = ^{do_peri[17:8], tx_count, rx_count};

  // Pin synchronisers; cs_n idles high so a reset never looks like a chip-select fall.
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      {sclk_s1, sclk_s2, sclk_q} <= 3'b000;
      {mosi_s1, mosi_s2}         <= 2'b00;
      {cs_s1, cs_s2, cs_q}       <= 3'b111;
    end else begin
      {sclk_s1, sclk_s2, sclk_q} <= {spi_sclk, sclk_s1, sclk_s2};
      {mosi_s1, mosi_s2}         <= {spi_mosi, mosi_s1};
      {cs_s1, cs_s2, cs_q}       <= {spi_cs_n, cs_s1, cs_s2};
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_q;
  assign sclk_fall   = ~sclk_s2 & sclk_q;
  assign lead_edge   = ctrl_q[CTRL_CPOL] ? sclk_fall : sclk_rise;
  assign trail_edge  = ctrl_q[CTRL_CPOL] ? sclk_rise : sclk_fall;
  assign sample_edge = ctrl_q[CTRL_CPHA] ? trail_edge : lead_edge;
  assign shift_edge  = ctrl_q[CTRL_CPHA] ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s2 & cs_q;
  assign cs_rise     = cs_s2 & ~cs_q;

  pselect #(
    .ADDR_WIDTH (4),
    .BASE_ADDR  (BASE_ADR[9:6])
  ) u_pselect (
    .addr       (addr_peri[9:6]),
    .activ_peri (access_peri),
    .select     (sel)
  );

  assign off       = addr_peri[5:0];
  assign bus_wr    = sel & wr_peri;
  assign bus_rd    = sel & ~wr_peri;
  assign status_wr = bus_wr & (off == REG_STATUS);
  assign ctrl_wr   = bus_wr & (off == REG_CTRL);
  assign tx_push   = bus_wr & (off == REG_DATA);
  assign rx_pop    = bus_rd & (off == REG_DATA) & ~rx_empty;

  spi_slave_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_peri (clk_peri),
    .reset    (reset),
    .push     (tx_push),
    .pop      (tx_pop),
    .wdata    (do_peri[7:0]),
    .rdata    (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  spi_slave_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_peri (clk_peri),
    .reset    (reset),
    .push     (rx_push),
    .pop      (rx_pop),
    .wdata    (rx_byte),
    .rdata    (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  assign rx_byte   = {rx_sr_q[6:0], mosi_s2};
  assign load_byte = tx_empty ? UNDERRUN_BYTE : tx_head;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    skip_d     = skip_q;
    done_d     = done_q;
    got_byte_d = got_byte_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    udr_set    = 1'b0;
    frame_set  = 1'b0;
    if (!ctrl_q[CTRL_EN] || cs_rise) begin
      frame_set  = ctrl_q[CTRL_EN] & got_byte_q;
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      miso_d     = 1'b0;
      skip_d     = 1'b0;
      done_d     = 1'b0;
      got_byte_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (cs_fall) state_d = StLoad;
        StLoad: begin
          tx_pop    = ~tx_empty;
          udr_set   = tx_empty;
          tx_sr_d   = load_byte;
          miso_d    = load_byte[7];
          bit_cnt_d = 3'd0;
          done_d    = 1'b0;
          // Only the first byte of a CPHA=1 frame sees a leading edge that must not shift;
          // later bytes enter LOAD on that very edge.
          skip_d    = ctrl_q[CTRL_CPHA] & ~got_byte_q;
          state_d   = StShift;
        end
        StShift: begin
          if (sample_edge && !done_q) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_push    = 1'b1;
              done_d     = 1'b1;
              got_byte_d = 1'b1;
            end
          end else if (shift_edge) begin
            if (done_q) begin
              state_d = StLoad;
            end else if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              miso_d  = tx_sr_q[6];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign ovr_set = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_sr_q    <= 8'h00;
      tx_sr_q    <= 8'h00;
      miso_q     <= 1'b0;
      skip_q     <= 1'b0;
      done_q     <= 1'b0;
      got_byte_q <= 1'b0;
      ctrl_q     <= 5'd0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      frame_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      skip_q     <= skip_d;
      done_q     <= done_d;
      got_byte_q <= got_byte_d;
      if (ctrl_wr) ctrl_q <= do_peri[4:0];
      // Sticky flags: a set event in the same cycle as a clear wins.
      ovr_q   <= (ovr_q & ~(status_wr & do_peri[ST_OVR])) | ovr_set;
      udr_q   <= (udr_q & ~(status_wr & do_peri[ST_UDR])) | udr_set;
      frame_q <= (frame_q & ~(status_wr & do_peri[ST_FRAME])) | frame_set;
      irq_q   <= (ctrl_q[CTRL_IE_RX] & ~rx_empty) | (ctrl_q[CTRL_IE_FRAME] & frame_q);
    end
  end

  assign status = {frame_q, ~cs_s2, udr_q, ovr_q, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    rd_val = 8'h00;
    case (off)
      REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_val = status;
      REG_CTRL:   rd_val = {3'b000, ctrl_q};
      default:    rd_val = 8'h00;
    endcase
  end

  assign di_peri     = bus_rd ? {10'b0, rd_val} : 18'b0;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = ctrl_q[CTRL_EN] & ~cs_s2 & (state_q != StIdle);
  assign irq         = irq_q;

endmodule

// File: tb/tb_spmc_spi_slave.sv
// Randomised scoreboard bench for spmc_spi_slave: an SPI master model drives the pins,
// a queue-based model of the FIFOs and flags predicts every bus read and MISO byte.
module tb_spmc_spi_slave;

  localparam int D    = 4;
  localparam int HALF = 8;  // clk_peri cycles per SCLK half period

  logic        clk_peri = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] do_peri = '0;
  logic [17:0] di_peri;
  logic [9:0]  addr_peri = '0;
  logic        access_peri = 1'b0;
  logic        wr_peri = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso, spi_miso_oe, irq;

  spmc_spi_slave u_dut (
    .clk_peri    (clk_peri),
    .reset       (reset),
    .do_peri     (do_peri),
    .di_peri     (di_peri),
    .addr_peri   (addr_peri),
    .access_peri (access_peri),
    .wr_peri     (wr_peri),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .irq         (irq)
  );

  always #5 clk_peri = ~clk_peri;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [17:0] val;
  } rd_exp_t;

  rd_exp_t    exp_rd[$];
  logic [7:0] exp_miso[$];
  logic [7:0] miso_obs;
  event       miso_ev;

  // Reference model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [4:0] m_ctrl = '0;
  bit         m_ovr, m_udr, m_frame;
  logic [7:0] m_loaded;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_frame, !spi_cs_n, m_udr, m_ovr, m_tx.size() == D, m_tx.size() == 0,
            m_rx.size() == D, m_rx.size() != 0};
  endfunction

  function automatic void m_load();
    if (m_tx.size() > 0) m_loaded = m_tx.pop_front();
    else begin
      m_loaded = 8'hFF;
      m_udr = 1;
    end
  endfunction

  function automatic void m_reset();
    m_tx.delete();
    m_rx.delete();
    m_ctrl = '0;
    m_ovr = 0;
    m_udr = 0;
    m_frame = 0;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk_peri);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] off, input logic [7:0] d);
    if (off == 0 && m_tx.size() < D) m_tx.push_back(d);
    if (off == 1) begin
      if (d[4]) m_ovr = 0;
      if (d[5]) m_udr = 0;
      if (d[7]) m_frame = 0;
    end
    if (off == 2) m_ctrl = d[4:0];
    addr_peri = {4'h0, off};
    do_peri = {10'b0, d};
    wr_peri = 1;
    access_peri = 1;
    clks(1);
    access_peri = 0;
    wr_peri = 0;
  endtask

  task automatic bus_rd(input logic [9:0] addr, input string name);
    rd_exp_t e;
    e.name = name;
    e.val = '0;
    if (addr[9:6] == 4'h0) begin
      case (addr[5:0])
        6'd0: if (m_rx.size() > 0) e.val = {10'b0, m_rx.pop_front()};
        6'd1: e.val = {10'b0, m_status()};
        6'd2: e.val = {13'b0, m_ctrl};
        default: e.val = '0;
      endcase
    end
    exp_rd.push_back(e);
    addr_peri = addr;
    wr_peri = 0;
    access_peri = 1;
    clks(1);
    access_peri = 0;
  endtask

  // Monitor: every bus read strobe is checked against the oldest queued prediction.
  initial forever begin
    @(negedge clk_peri);
    if (access_peri && !wr_peri) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_exp_t e;
        e = exp_rd.pop_front();
        chk(e.name, di_peri, e.val);
      end
    end
  end

  initial forever begin
    @(miso_ev);
    if (exp_miso.size() == 0) chk("miso_unexpected", 1, 0);
    else chk("miso_byte", miso_obs, exp_miso.pop_front());
  end

  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    bit cpol, cpha;
    cpol = m_ctrl[1];
    cpha = m_ctrl[0];
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        spi_mosi = mo[7-i];
        clks(HALF);
        spi_sclk = ~cpol;
        mi[7-i] = spi_miso;
        clks(HALF);
        spi_sclk = cpol;
      end else begin
        spi_sclk = ~cpol;
        spi_mosi = mo[7-i];
        clks(HALF);
        spi_sclk = cpol;
        mi[7-i] = spi_miso;
        clks(HALF);
      end
    end
  endtask

  task automatic cs_begin();
    spi_sclk = m_ctrl[1];
    clks(4);
    spi_cs_n = 0;
    if (m_ctrl[2]) m_load();
    clks(16);
  endtask

  // Full frame: nbytes bytes, the last one cut to lastbits bits.
  task automatic frame(input int nbytes, input int lastbits);
    logic [7:0] mo, mi;
    bit got;
    got = 0;
    cs_begin();
    for (int b = 0; b < nbytes; b++) begin
      int nb;
      nb = (b == nbytes - 1) ? lastbits : 8;
      mo = 8'($urandom);
      if (m_ctrl[2] && m_ctrl[0] && b > 0) m_load();
      if (m_ctrl[2] && nb == 8) exp_miso.push_back(m_loaded);
      xfer_bits(mo, nb, mi);
      if (nb == 8 && m_ctrl[2]) begin
        got = 1;
        if (m_rx.size() < D) m_rx.push_back(mo);
        else m_ovr = 1;
        miso_obs = mi;
        -> miso_ev;
        if (!m_ctrl[0]) m_load();
      end
    end
    clks(HALF);
    spi_cs_n = 1;
    if (m_ctrl[2] && got) m_frame = 1;
    clks(16);
  endtask

  task automatic drain_rx(input string name);
    int n;
    n = m_rx.size();
    for (int i = 0; i <= n; i++) bus_rd(10'd0, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mo, mi;
    clks(4);
    reset = 0;
    clks(2);

    // Reset state
    chk("reset_miso", spi_miso, 0);
    chk("reset_oe", spi_miso_oe, 0);
    chk("reset_irq", irq, 0);
    bus_rd(10'd1, "reset_status");
    bus_rd(10'd2, "reset_ctrl");
    bus_rd(10'd0, "reset_data_empty");
    bus_wr(6'd5, 8'hFF);
    bus_rd(10'd5, "unmapped_offset");
    bus_rd(10'h042, "unselected_base");

    // Mode 0, single byte with TX preloaded
    bus_wr(6'd2, 8'h04);
    bus_wr(6'd0, 8'hA5);
    bus_rd(10'd1, "m0_status_pre");
    frame(1, 8);
    bus_rd(10'd1, "m0_status_post");
    bus_rd(10'd0, "m0_data");
    bus_rd(10'd1, "m0_status_drained");
    bus_wr(6'd1, 8'hB0);
    bus_rd(10'd1, "m0_status_cleared");

    // Mode 3, three bytes, two queued -> underrun on the third
    bus_wr(6'd2, 8'h07);
    bus_wr(6'd0, 8'h11);
    bus_wr(6'd0, 8'h22);
    frame(3, 8);
    bus_rd(10'd1, "m3_status");
    bus_wr(6'd1, 8'h20);
    bus_rd(10'd1, "m3_udr_cleared");
    drain_rx("m3_data");

    // Overrun: five bytes without reads
    bus_wr(6'd2, 8'h04);
    frame(5, 8);
    bus_rd(10'd1, "ovr_status");
    drain_rx("ovr_data");
    bus_wr(6'd1, 8'hB0);

    // Partial second byte discarded, next frame clean
    bus_wr(6'd2, 8'h05);
    bus_wr(6'd0, 8'h5A);
    frame(2, 5);
    bus_rd(10'd1, "partial_status");
    drain_rx("partial_data");
    frame(1, 8);
    drain_rx("after_partial_data");
    bus_wr(6'd1, 8'hB0);

    // RX interrupt rises on receive, falls once drained
    bus_wr(6'd2, 8'h0C);
    frame(1, 8);
    chk("irq_rx_set", irq, 1);
    bus_rd(10'd0, "irq_data");
    clks(2);
    chk("irq_rx_clear", irq, 0);

    // EN dropped mid-byte
    bus_wr(6'd2, 8'h04);
    cs_begin();
    xfer_bits(8'h96, 3, mi);
    chk("oe_active", spi_miso_oe, 1);
    bus_wr(6'd2, 8'h00);
    chk("oe_en_off", spi_miso_oe, 0);
    xfer_bits(8'h96, 5, mi);
    clks(HALF);
    spi_cs_n = 1;
    clks(16);
    bus_rd(10'd1, "en_off_status");
    bus_wr(6'd1, 8'hB0);

    // Randomised frames
    for (int it = 0; it < 14; it++) begin
      int npush, nbytes, lastbits;
      bus_wr(6'd2, 8'h04 | 8'($urandom_range(0, 3)) | (it[0] ? 8'h10 : 8'h00));
      npush = $urandom_range(0, 5);
      for (int k = 0; k < npush; k++) bus_wr(6'd0, 8'($urandom));
      nbytes = $urandom_range(1, 3);
      lastbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      frame(nbytes, lastbits);
      bus_rd(10'd1, "rand_status");
      drain_rx("rand_data");
      bus_wr(6'd1, 8'($urandom));
      bus_rd(10'd1, "rand_status_clr");
    end

    // Reset in the middle of a byte
    bus_wr(6'd2, 8'h04);
    frame(1, 8);
    bus_wr(6'd0, 8'h33);
    bus_wr(6'd0, 8'h44);
    cs_begin();
    xfer_bits(8'hC3, 4, mi);
    reset = 1;
    m_reset();
    clks(2);
    reset = 0;
    clks(1);
    chk("rst_mid_miso", spi_miso, 0);
    chk("rst_mid_oe", spi_miso_oe, 0);
    chk("rst_mid_irq", irq, 0);
    spi_cs_n = 1;
    clks(16);
    bus_rd(10'd1, "rst_mid_status");
    bus_rd(10'd0, "rst_mid_data");
    bus_rd(10'd2, "rst_mid_ctrl");

    for (int w = 0; w < 50 && exp_rd.size() != 0; w++) clks(1);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spmc_spi_slave.md
Name: spmc_spi_slave

Overview:
- SpartanMC peripheral acting as the SPI responder (slave) side of the SPI link driven by the SD-card SPI master.
- Lets a SpartanMC emulate an SPI device (SD-card model, inter-FPGA link) toward an external SPI master.
- Samples SCLK/MOSI/CS_n in the clk_peri domain; byte-wide RX and TX FIFOs are accessed through the 18-bit peripheral bus.

Parameters:
- BASE_ADR, 10'h0, peripheral base address; must be divisible by 64.
- FIFO_DEPTH, 4, entries per RX and TX FIFO; power of two, 2..16.
- UNDERRUN_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at byte start.

Ports:
- clk_peri, in, 1, system clock; the only clock.
- reset, in, 1, synchronous, active-high.
- do_peri, in, 18, data from MC; bits [7:0] used.
- di_peri, out, 18, data to MC; {10'b0, reg} when selected and reading, else 0.
- addr_peri, in, 10, [9:6] decoded against BASE_ADR; [5:0] register offset.
- access_peri, in, 1, peripheral access strobe.
- wr_peri, in, 1, write enable.
- spi_sclk, in, 1, async SPI clock from the master.
- spi_mosi, in, 1, async serial data in.
- spi_cs_n, in, 1, async chip select, active low.
- spi_miso, out, 1, serial data out.
- spi_miso_oe, out, 1, high while enabled and CS active (pad tristate control).
- irq, out, 1, level interrupt.

Behaviour:
- Register map (offset): 0 DATA (write: push TX; read: RX head plus pop); 1 STATUS; 2 CTRL (R/W). Other offsets read 0; writes to them are ignored.
- CTRL fields: [0] CPHA, [1] CPOL, [2] EN, [3] IE_RX, [4] IE_FRAME. Reset value 0.
- STATUS fields:
  - [0] rx_nempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] OVR, [5] UDR, [6] cs_active, [7] FRAME.
  - Bits 4, 5 and 7 are sticky. Writing 1 to any of them clears it.
  - A set event coinciding with a clear leaves the bit set.
- Reset values: spi_miso=0, spi_miso_oe=0, irq=0, both FIFOs empty, all sticky bits 0, bit counter 0.
- Input synchronisation:
  - sclk, mosi and cs_n each pass through two flops.
  - Edges are detected on the synchronised sclk.
  - Requirement: f_sclk <= f_clk_peri/8.
- Leading edge is the transition away from CPOL; trailing edge is the transition back to CPOL.
  - CPHA=0: sample MOSI on leading, shift MISO on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- Engine states: IDLE, LOAD, SHIFT.
  - IDLE -> LOAD on synchronised CS fall while EN=1.
  - LOAD (1 cycle): pop the TX head into the shift register, or load UNDERRUN_BYTE and set UDR if the TX FIFO is empty. Drive MSB on spi_miso. Go to SHIFT.
  - SHIFT, CPHA=1: the first leading edge does not shift; MSB stays held.
  - SHIFT, 8th sample: push the assembled byte into RX (MSB first). If RX is full, drop the byte and set OVR. Then go to LOAD for the next byte on the following edge.
  - Any state -> IDLE on synchronised CS rise: partial byte discarded, counter cleared, FRAME set only if at least one full byte was transferred, spi_miso_oe=0 in the same cycle.
- Latency:
  - RX byte visible in STATUS 1 cycle after the synchronised sampling edge, i.e. at most 4 clk_peri after the pin edge.
  - MISO changes within 4 clk_peri of the pin edge or CS fall.
- EN=0 forces the engine to IDLE immediately and holds it there; FIFO contents are kept.
- Bus access:
  - Push/pop happen in the cycle where select & access_peri. Read data is combinational, same cycle.
  - TX write when full: byte dropped, no flag.
  - RX read when empty: returns 0, no pop.
  - Engine RX push and bus pop in the same cycle: both are honoured, count unchanged.
  - Same rule for TX push and engine pop.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap; the count is one bit wider.
- irq = (IE_RX & rx_nempty) | (IE_FRAME & FRAME), registered, 1 cycle latency.
- Reset mid-frame: everything returns to reset values; the engine waits for a fresh CS fall.

Decomposition:
- Package spmc_spi_slave_pkg: register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2); CTRL and STATUS bit indices; engine state encoding.
- Sub-module spi_slave_fifo (parameters WIDTH=8, DEPTH): synchronous, push/pop/full/empty/count. Instantiated twice.
- Address decode uses the existing pselect with BASE_ADDR = BASE_ADR>>6.

Test Plan:
- Mode 0 (CTRL=0x04), TX preloaded 0xA5, master sends 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; DATA reads 0x3C; STATUS[0] returns to 0 after the read; FRAME=1 after CS rise.
- Mode 3 (CTRL=0x07), 3-byte frame, TX holds 0x11 and 0x22 -> master receives 0x11, 0x22, 0xFF; UDR=1; writing STATUS 0x20 clears UDR.
- No reads during 5 incoming bytes with FIFO_DEPTH=4 -> RX holds bytes 1-4, byte 5 dropped, OVR=1, rx_full=1.
- CS rises after 5 bits of the second byte -> RX holds exactly 1 byte, counter cleared; next frame's first byte is received correctly.
- IE_RX=1: irq rises within 5 clk_peri of the 8th sample edge and falls 1 cycle after RX is drained; EN=0 mid-byte -> spi_miso_oe=0 next cycle, no RX push.
- Reset asserted mid-SHIFT -> all outputs 0, FIFOs empty, STATUS reads 0x04.
